// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: fetch port, data port and the
// single-ported memory side. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives the requests and the memory.
interface unified_mem_arbiter_if #(
  parameter int N = 32
);
  // Fetch (IF) port
  logic         if_req;
  logic [N-1:0] if_addr;
  logic         if_done;
  logic [N-1:0] if_rdata;
  logic         if_stall;
  // Load/store (D) port
  logic         d_req;
  logic         d_we;
  logic [1:0]   d_size;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic         d_done;
  logic [N-1:0] d_rdata;
  logic         d_misalign;
  logic         d_stall;
  // Memory side
  logic         mem_en;
  logic         mem_we;
  logic [1:0]   mem_size;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, if_stall, d_done, d_rdata, d_misalign, d_stall,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, if_stall, d_done, d_rdata, d_misalign, d_stall,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch
// (IF) and load/store (D). Each access runs IDLE -> ISSUE -> WAIT -> RESP;
// misaligned data ops skip the memory and go straight to RESP. D normally wins
// a tie, but after STARVE_MAX consecutive D grants with IF waiting, IF wins.
module unified_mem_arbiter #(
  parameter int N          = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input logic                    clk,
  input logic                    rst,
  unified_mem_arbiter_if.slave   bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Size encoding: 00 byte, 01 half, 10/11 word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  state_t        state_q;
  logic          owner_d_q;     // 1: current access belongs to D, 0: to IF
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] streak_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [1:0]    mem_size_q;
  logic [N-1:0]  mem_addr_q;
  logic [N-1:0]  mem_wdata_q;
  logic          if_done_q;
  logic [N-1:0]  if_rdata_q;
  logic          d_done_q;
  logic [N-1:0]  d_rdata_q;
  logic          d_misalign_q;

  logic pick_d_d;
  logic pick_if_d;
  logic d_misal_d;

  // Arbitration decision for the current IDLE cycle
  always_comb begin
    pick_d_d  = 1'b0;
    pick_if_d = 1'b0;
    d_misal_d = is_misaligned(bus.d_size, bus.d_addr[1:0]);
    if (bus.if_req && bus.d_req) begin
      if (streak_q == STREAK_MAX) begin
        pick_if_d = 1'b1;
      end else begin
        pick_d_d = 1'b1;
      end
    end else if (bus.d_req) begin
      pick_d_d = 1'b1;
    end else if (bus.if_req) begin
      pick_if_d = 1'b1;
    end else begin
      pick_d_d  = 1'b0;
      pick_if_d = 1'b0;
    end
  end

  // Access sequencer: grant, issue, latency wait, response, with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_d_q    <= 1'b0;
      cnt_q        <= '0;
      streak_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_size_q   <= 2'b00;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_done_q     <= 1'b0;
      d_rdata_q    <= '0;
      d_misalign_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_d_d) begin
            owner_d_q <= 1'b1;
            if (bus.if_req && (streak_q != STREAK_MAX)) begin
              streak_q <= streak_q + STREAK_ONE;
            end
            if (d_misal_d) begin
              // Rejected op: respond immediately without touching memory.
              state_q      <= S_RESP;
              d_done_q     <= 1'b1;
              d_misalign_q <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              mem_en_q    <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_size_q  <= bus.d_size;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end
          end else if (pick_if_d) begin
            owner_d_q   <= 1'b0;
            streak_q    <= '0;
            state_q     <= S_ISSUE;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'b10;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
          end
        end
        S_ISSUE: begin
          mem_en_q <= 1'b0;
          cnt_q    <= CNT_INIT;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_RESP;
            if (owner_d_q) begin
              d_done_q     <= 1'b1;
              d_misalign_q <= 1'b0;
              if (!mem_we_q) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_RESP: begin
          // Requests are deliberately not sampled here; next grant is from IDLE.
          if_done_q    <= 1'b0;
          d_done_q     <= 1'b0;
          d_misalign_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_size   = mem_size_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.if_done    = if_done_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_done     = d_done_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_misalign = d_misalign_q;
  assign bus.if_stall   = bus.if_req & ~if_done_q;
  assign bus.d_stall    = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one DUT with MEM_LAT=1 and one with
// MEM_LAT=3. The memory model returns data only in the valid cycle and junk
// otherwise, so a capture on the wrong edge shows up as a wrong rdata.
module tb_unified_mem_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [31:0] rd_val1;
  logic [31:0] rd_val3;
  logic        v1_q;
  logic [2:0]  v3_q;

  unified_mem_arbiter_if #(.N(32)) b1 ();
  unified_mem_arbiter_if #(.N(32)) b3 ();

  unified_mem_arbiter #(.N(32), .MEM_LAT(1), .STARVE_MAX(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  unified_mem_arbiter #(.N(32), .MEM_LAT(3), .STARVE_MAX(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: data valid exactly MEM_LAT cycles after the mem_en cycle.
  always @(posedge clk) begin
    v1_q <= b1.mem_en;
    v3_q <= {v3_q[1:0], b3.mem_en};
  end
  assign b1.mem_rdata = v1_q    ? rd_val1 : 32'hDEAD_DEAD;
  assign b3.mem_rdata = v3_q[2] ? rd_val3 : 32'hDEAD_DEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (b1.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b exp 0", b1.mem_en); end
    n_tests++; if ({b1.if_done, b1.d_done, b1.d_misalign} !== 3'b000) begin n_fail++; $display("FAIL reset_done got %b exp 000", {b1.if_done, b1.d_done, b1.d_misalign}); end
    n_tests++; if ((b1.if_rdata | b1.d_rdata | b1.mem_addr) !== 32'h0) begin n_fail++; $display("FAIL reset_regs got %h exp 0", b1.if_rdata | b1.d_rdata | b1.mem_addr); end
    n_tests++; if (b3.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en3 got %b exp 0", b3.mem_en); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
  endtask

  // Single fetch: mem_en cycle 1, if_done with data cycle 3.
  task automatic test_if_only(input logic [31:0] addr, input logic [31:0] data, input string tag);
    int men_n, men_cyc, done_cyc, stall_bad, d_done_n;
    logic [31:0] a_en, rd;
    logic we_en;
    logic [1:0] sz_en;
    men_n = 0; men_cyc = -1; done_cyc = -1; stall_bad = 0; d_done_n = 0;
    a_en = '0; rd = '0; we_en = 1'b1; sz_en = 2'b00;
    rd_val1 = data; b1.if_addr = addr; b1.if_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b1.mem_en) begin men_n++; men_cyc = c; a_en = b1.mem_addr; we_en = b1.mem_we; sz_en = b1.mem_size; end
      if (b1.if_done) begin done_cyc = c; rd = b1.if_rdata; end
      if (b1.d_done) d_done_n++;
      if (b1.if_stall !== (c < 3)) stall_bad++;
      @(posedge clk); #1;
      if (c == 3) b1.if_req = 1'b0;
    end
    n_tests++; if (men_n !== 1 || men_cyc !== 1) begin n_fail++; $display("FAIL %s mem_en got n=%0d cyc=%0d exp n=1 cyc=1", tag, men_n, men_cyc); end
    n_tests++; if ({a_en, we_en, sz_en} !== {addr, 1'b0, 2'b10}) begin n_fail++; $display("FAIL %s mem_bus got %h/%b/%b exp %h/0/10", tag, a_en, we_en, sz_en, addr); end
    n_tests++; if (done_cyc !== 3) begin n_fail++; $display("FAIL %s if_done_cycle got %0d exp 3", tag, done_cyc); end
    n_tests++; if (rd !== data) begin n_fail++; $display("FAIL %s if_rdata got %h exp %h", tag, rd, data); end
    n_tests++; if (stall_bad !== 0 || d_done_n !== 0) begin n_fail++; $display("FAIL %s stall/d_done got %0d/%0d exp 0/0", tag, stall_bad, d_done_n); end
  endtask

  // Both requesters held: grant order D, D, IF, D, D, IF.
  task automatic test_starvation();
    logic [31:0] g [0:5];
    logic [31:0] exp_g [0:5];
    int n, d_n, i_n, back2back;
    logic prev_en;
    n = 0; d_n = 0; i_n = 0; back2back = 0; prev_en = 1'b0;
    exp_g[0] = 32'h100; exp_g[1] = 32'h100; exp_g[2] = 32'h40;
    exp_g[3] = 32'h100; exp_g[4] = 32'h100; exp_g[5] = 32'h40;
    for (int k = 0; k < 6; k++) g[k] = 32'hFFFF_FFFF;
    rd_val1 = 32'h1122_3344;
    b1.if_addr = 32'h40; b1.d_addr = 32'h100; b1.d_we = 1'b0; b1.d_size = 2'b10;
    b1.if_req = 1'b1; b1.d_req = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (b1.mem_en) begin
        if (n < 6) g[n] = b1.mem_addr;
        n++;
        if (prev_en) back2back++;
      end
      prev_en = b1.mem_en;
      if (b1.d_done) d_n++;
      if (b1.if_done) i_n++;
      @(posedge clk); #1;
    end
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    tick(); tick();
    n_tests++; if (n !== 6) begin n_fail++; $display("FAIL starve_grants got %0d exp 6", n); end
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (g[k] !== exp_g[k]) begin n_fail++; $display("FAIL starve_order[%0d] got %h exp %h", k, g[k], exp_g[k]); end
    end
    n_tests++; if (d_n !== 4 || i_n !== 2) begin n_fail++; $display("FAIL starve_dones got d=%0d if=%0d exp d=4 if=2", d_n, i_n); end
    n_tests++; if (b1.d_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL starve_d_rdata got %h exp 11223344", b1.d_rdata); end
    n_tests++; if (back2back !== 0) begin n_fail++; $display("FAIL starve_mem_en_b2b got %0d exp 0", back2back); end
  endtask

  // Half-word store: one write strobe, d_rdata untouched.
  task automatic test_store_half();
    int men_n, done_cyc;
    logic [31:0] a_en, wd_en;
    logic we_en, mis;
    logic [1:0] sz_en;
    men_n = 0; done_cyc = -1; a_en = '0; wd_en = '0; we_en = 1'b0; sz_en = 2'b00; mis = 1'b1;
    b1.d_we = 1'b1; b1.d_size = 2'b01; b1.d_addr = 32'h102; b1.d_wdata = 32'h0000_BEEF;
    b1.d_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b1.mem_en) begin men_n++; a_en = b1.mem_addr; wd_en = b1.mem_wdata; we_en = b1.mem_we; sz_en = b1.mem_size; end
      if (b1.d_done) begin done_cyc = c; mis = b1.d_misalign; end
      @(posedge clk); #1;
      if (c == 3) b1.d_req = 1'b0;
    end
    n_tests++; if (men_n !== 1) begin n_fail++; $display("FAIL store_mem_en_count got %0d exp 1", men_n); end
    n_tests++; if ({we_en, sz_en, a_en, wd_en} !== {1'b1, 2'b01, 32'h102, 32'h0000_BEEF}) begin n_fail++; $display("FAIL store_bus got we=%b sz=%b a=%h wd=%h exp 1/01/102/0000beef", we_en, sz_en, a_en, wd_en); end
    n_tests++; if (done_cyc !== 3 || mis !== 1'b0) begin n_fail++; $display("FAIL store_done got cyc=%0d mis=%b exp 3/0", done_cyc, mis); end
    n_tests++; if (b1.d_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL store_d_rdata got %h exp 11223344", b1.d_rdata); end
    b1.d_we = 1'b0;
  endtask

  // Alignment rules across sizes; rejected loads never reach memory.
  task automatic test_misalign();
    logic [1:0]  sz_t  [0:3];
    logic [31:0] ad_t  [0:3];
    logic        mis_t [0:3];
    logic [31:0] exp_rd;
    int men_n, done_cyc;
    logic mis;
    sz_t[0] = 2'b10; ad_t[0] = 32'h103; mis_t[0] = 1'b1;
    sz_t[1] = 2'b01; ad_t[1] = 32'h101; mis_t[1] = 1'b1;
    sz_t[2] = 2'b11; ad_t[2] = 32'h102; mis_t[2] = 1'b1;
    sz_t[3] = 2'b00; ad_t[3] = 32'h103; mis_t[3] = 1'b0;
    exp_rd = 32'h1122_3344;
    rd_val1 = 32'h0000_00AB;
    for (int v = 0; v < 4; v++) begin
      men_n = 0; done_cyc = -1; mis = 1'bx;
      b1.d_we = 1'b0; b1.d_size = sz_t[v]; b1.d_addr = ad_t[v]; b1.d_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (b1.mem_en) men_n++;
        if (b1.d_done) begin done_cyc = c; mis = b1.d_misalign; end
        @(posedge clk); #1;
        if (done_cyc == c) b1.d_req = 1'b0;
      end
      if (!mis_t[v]) exp_rd = rd_val1;
      n_tests++; if (done_cyc !== (mis_t[v] ? 1 : 3) || mis !== mis_t[v]) begin n_fail++; $display("FAIL misalign[%0d] done got cyc=%0d mis=%b exp cyc=%0d mis=%b", v, done_cyc, mis, (mis_t[v] ? 1 : 3), mis_t[v]); end
      n_tests++; if (men_n !== (mis_t[v] ? 0 : 1)) begin n_fail++; $display("FAIL misalign[%0d] mem_en got %0d exp %0d", v, men_n, (mis_t[v] ? 0 : 1)); end
      n_tests++; if (b1.d_rdata !== exp_rd) begin n_fail++; $display("FAIL misalign[%0d] d_rdata got %h exp %h", v, b1.d_rdata, exp_rd); end
    end
  endtask

  // MEM_LAT=3 load: mem_en cycle 1, d_done cycle 5, d_stall high cycles 0-4.
  task automatic test_lat3();
    int men_cyc, done_cyc, stall_bad;
    logic [31:0] rd;
    men_cyc = -1; done_cyc = -1; stall_bad = 0; rd = '0;
    rd_val3 = 32'hCAFE_F00D;
    b3.d_we = 1'b0; b3.d_size = 2'b10; b3.d_addr = 32'h200; b3.d_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b3.mem_en) men_cyc = c;
      if (b3.d_done) begin done_cyc = c; rd = b3.d_rdata; end
      if (b3.d_stall !== (c < 5)) stall_bad++;
      @(posedge clk); #1;
      if (c == 5) b3.d_req = 1'b0;
    end
    n_tests++; if (men_cyc !== 1) begin n_fail++; $display("FAIL lat3_mem_en_cycle got %0d exp 1", men_cyc); end
    n_tests++; if (done_cyc !== 5) begin n_fail++; $display("FAIL lat3_done_cycle got %0d exp 5", done_cyc); end
    n_tests++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat3_d_rdata got %h exp cafef00d", rd); end
    n_tests++; if (stall_bad !== 0) begin n_fail++; $display("FAIL lat3_d_stall got %0d bad cycles exp 0", stall_bad); end
  endtask

  // Reset during WAIT aborts silently; a later fetch completes normally.
  task automatic test_reset_mid();
    int bad;
    bad = 0;
    rd_val1 = 32'h5555_AAAA;
    b1.if_addr = 32'h20; b1.if_req = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++; if ({b1.mem_en, b1.if_done} !== 2'b00 || b1.if_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_immediate got en/done=%b rdata=%h exp 00/0", {b1.mem_en, b1.if_done}, b1.if_rdata); end
    b1.if_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b1.mem_en || b1.if_done || b1.d_done) bad++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (b1.mem_en || b1.if_done || b1.d_done) bad++;
      @(posedge clk); #1;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d bad cycles exp 0", bad); end
    test_if_only(32'h30, 32'h0BAD_C0DE, "rstmid_refetch");
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rd_val1 = '0; rd_val3 = '0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_size = 2'b00; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_size = 2'b00; b3.d_addr = '0; b3.d_wdata = '0;
    test_reset();
    test_if_only(32'h10, 32'h0050_0093, "if_only");
    test_starvation();
    test_store_half();
    test_misalign();
    test_lat3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
